// File: rtl/syndcnt_pkg.sv
// Shared types and helpers for the syndcnt_reload down-counter slice.
// The optional reload register is enabled by defining SYNDCNT_RELOAD_EN.
package syndcnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } syndcntState_e;

    localparam int MAX_WIDTH = 32;

    // Constant all-ones mask of the requested width, usable in parameter context.
    function automatic logic [MAX_WIDTH-1:0] allOnes(input int width);
        logic [MAX_WIDTH-1:0] ones;
        ones = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                ones[i] = 1'b1;
            end
        end
        return ones;
    endfunction

endpackage

// File: rtl/syndcnt_ctl.sv
// One-shot arm/expire FSM and sticky underflow flag for syndcnt_reload.
// Produces the counting-allowed, hold-at-zero, underflow and ARMED controls.
module syndcnt_ctl
    import syndcnt_pkg::*;
#(
    parameter int ONESHOT = 0
) (
    input  logic clk_i,
    input  logic resl_i,
    input  logic ldl_i,
    input  logic ci_i,
    input  logic zero_i,
    input  logic ackl_i,
    output logic countEn_o,
    output logic holdZero_o,
    output logic uflow_o,
    output logic armed_o,
    output logic ufl_o
);

    localparam syndcntState_e RESET_STATE = (ONESHOT != 0) ? IDLE : RUN;

    syndcntState_e state_q, state_d;
    logic          ufl_q, ufl_d;

    always_ff @(posedge clk_i or negedge resl_i) begin
        if (!resl_i) begin
            state_q <= RESET_STATE;
            ufl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ufl_q   <= ufl_d;
        end
    end

    always_comb begin
        countEn_o  = (state_q == RUN);
        uflow_o    = ci_i & zero_i & countEn_o;
        holdZero_o = uflow_o & (ONESHOT != 0);
        armed_o    = countEn_o;
        ufl_o      = ufl_q;

        // Setting on underflow takes precedence over an acknowledge on the same edge.
        ufl_d = ufl_q;
        if (uflow_o) begin
            ufl_d = 1'b1;
        end else if (!ackl_i) begin
            ufl_d = 1'b0;
        end

        state_d = state_q;
        if (ONESHOT == 0) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!ldl_i) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (ldl_i && uflow_o) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (!ldl_i) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/syndcnt_reload.sv
// Parametrised cascadable down-counter with preset, parallel load, sticky underflow
// and one-shot mode. Define SYNDCNT_RELOAD_EN to add the programmable reload register.
module syndcnt_reload
    import syndcnt_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ONESHOT = 0
) (
    input  logic             clk_i,
    input  logic             resl_i,
    input  logic             prl_i,
    input  logic             ldl_i,
    input  logic [WIDTH-1:0] ldv_i,
    input  logic             ci_i,
    input  logic             ackl_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qb_o,
    output logic             co_o,
    output logic             ufl_o,
    output logic             armed_o
`ifdef SYNDCNT_RELOAD_EN
    ,
    output logic [WIDTH-1:0] rldq_o
`endif
);

    localparam logic [MAX_WIDTH-1:0] ONES_FULL = allOnes(WIDTH);
    localparam logic [WIDTH-1:0]     ALL_ONES  = ONES_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] wrapVal;
    logic             zero;
    logic             countEn;
    logic             holdZero;
    logic             uflow;

    assign zero = (count_q == '0);

    syndcnt_ctl #(
        .ONESHOT(ONESHOT)
    ) u_ctl (
        .clk_i      (clk_i),
        .resl_i     (resl_i),
        .ldl_i      (ldl_i),
        .ci_i       (ci_i),
        .zero_i     (zero),
        .ackl_i     (ackl_i),
        .countEn_o  (countEn),
        .holdZero_o (holdZero),
        .uflow_o    (uflow),
        .armed_o    (armed_o),
        .ufl_o      (ufl_o)
    );

`ifdef SYNDCNT_RELOAD_EN
    logic [WIDTH-1:0] rld_q, rld_d;

    always_ff @(posedge clk_i or negedge resl_i) begin
        if (!resl_i) begin
            rld_q <= ALL_ONES;
        end else begin
            rld_q <= rld_d;
        end
    end

    // Reset value of all ones keeps the wrap identical to the plain counter until a load.
    always_comb begin
        rld_d   = ldl_i ? rld_q : ldv_i;
        wrapVal = (ONESHOT == 0) ? rld_q : ALL_ONES;
    end

    assign rldq_o = rld_q;
`else
    assign wrapVal = ALL_ONES;
`endif

    always_ff @(posedge clk_i or negedge resl_i) begin
        if (!resl_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (!prl_i) begin
            count_d = ALL_ONES;
        end else if (!ldl_i) begin
            count_d = ldv_i;
        end else if (countEn && ci_i) begin
            if (holdZero) begin
                count_d = count_q;
            end else if (zero) begin
                count_d = wrapVal;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    assign q_o  = count_q;
    assign qb_o = ~count_q;
    assign co_o = uflow;

endmodule
